// File: rtl/lsu_mem_sequencer_pkg.sv
// Shared constants for the LSU memory sequencer: func3 codes, FSM states, access sizes.
// The misaligned-trap option is LSU_MISALIGN_TRAP_EN, consumed by lsu_mem_sequencer.
package lsu_mem_sequencer_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] BYTES_B = 3'd1;
    localparam logic [2:0] BYTES_H = 3'd2;
    localparam logic [2:0] BYTES_W = 3'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, FAULT} state_e;

    function automatic logic [2:0] f3_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return BYTES_B;
            2'b01:   return BYTES_H;
            default: return BYTES_W;
        endcase
    endfunction

    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        if (wr) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_mem_sequencer_load_ext.sv
// Combinational load extender: sign/zero extends a raw little-endian value by func3.
module lsu_load_ext
    import lsu_mem_sequencer_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (func3)
            F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  ext = {24'b0, raw[7:0]};
            F3_LHU:  ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: aligned accesses go straight to memory, misaligned ones are split into bytes.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of splitting them.
module lsu_mem_sequencer
    import lsu_mem_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        func3_q, func3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [31:0] asm_next, ext_raw, ext_out;
    logic        last_byte, misaligned;

    lsu_load_ext u_ext (
        .func3 (func3_q),
        .raw   (ext_raw),
        .ext   (ext_out)
    );

    // Memory side is purely a function of state so reset silences it immediately.
    always_comb begin
        asm_next = asm_q;
        asm_next[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
        last_byte = ({1'b0, cnt_q} == (f3_bytes(func3_q) - 3'd1));
        ext_raw   = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_func3 = 3'b000;
        mem_addr  = '0;
        mem_wdata = 32'b0;
        case (state_q)
            ACCESS: begin
                mem_read  = ~write_q;
                mem_write = write_q;
                mem_func3 = func3_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            SPLIT: begin
                mem_read  = ~write_q;
                mem_write = write_q;
                mem_func3 = write_q ? F3_SB : F3_LBU;
                mem_addr  = addr_q + ADDR_W'(cnt_q);
                mem_wdata = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
                ext_raw   = asm_next;
            end
            default: ;
        endcase
    end

    always_comb begin
        misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        state_d     = state_q;
        write_d     = write_q;
        func3_d     = func3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    asm_d   = 32'b0;
                    if (!f3_legal(req_write, req_func3)) state_d = FAULT;
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (misaligned)                 state_d = FAULT;
`else
                    else if (misaligned)                 state_d = SPLIT;
`endif
                    else                                 state_d = ACCESS;
                end
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = write_q ? 32'b0 : ext_out;
                state_d     = IDLE;
            end
            SPLIT: begin
                asm_d = asm_next;
                cnt_d = cnt_q + 2'd1;
                if (last_byte) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? 32'b0 : ext_out;
                    cnt_d       = 2'd0;
                    state_d     = IDLE;
                end
            end
            FAULT: begin
                rsp_valid_d = 1'b1;
                rsp_fault_d = 1'b1;
                rsp_rdata_d = 32'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            func3_q     <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'b0;
            cnt_q       <= 2'd0;
            asm_q       <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            func3_q     <= func3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: byte-array memory model plus a response scoreboard.
module tb_lsu_mem_sequencer;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_func3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_func3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb[$];
    logic [7:0]  mem [256];
    logic [7:0]  a1, a2, a3;

    lsu_mem_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        a1 = mem_addr + 8'd1;
        a2 = mem_addr + 8'd2;
        a3 = mem_addr + 8'd3;
        mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_func3 != 3'b000) mem[a1] <= mem_wdata[15:8];
            if (mem_func3 == 3'b010) begin
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e[31:0]);
                check("rsp_fault", 32'(rsp_fault), 32'(e[32]));
            end
        end
    end

    // Called just after a negedge; returns 1ns after the accept edge T.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, input logic [32:0] exp, input bit push);
        req_valid = 1'b1; req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd;
        check("ready_at_accept", 32'(req_ready), 32'd1);
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic exp_acc(input string tag, input logic w, input logic [2:0] f3,
                           input logic [7:0] a, input logic [7:0] wb);
        @(negedge clk);
        check($sformatf("%s_rd@%h", tag, a), 32'(mem_read), 32'(!w));
        check($sformatf("%s_wr@%h", tag, a), 32'(mem_write), 32'(w));
        check($sformatf("%s_f3@%h", tag, a), 32'(mem_func3), 32'(f3));
        check($sformatf("%s_addr", tag), 32'(mem_addr), 32'(a));
        if (w) check($sformatf("%s_wdata@%h", tag, a), 32'(mem_wdata[7:0]), 32'(wb));
        check($sformatf("%s_busy", tag), 32'(req_ready), 32'd0);
        check($sformatf("%s_early_rsp", tag), 32'(rsp_valid), 32'd0);
    endtask

    task automatic exp_fault_cycle(input string tag);
        @(negedge clk);
        check({tag, "_no_rd"}, 32'(mem_read), 32'd0);
        check({tag, "_no_wr"}, 32'(mem_write), 32'd0);
        check({tag, "_busy"}, 32'(req_ready), 32'd0);
        check({tag, "_early_rsp"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic exp_rsp(input string tag);
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_func3 = 3'b000; req_addr = 8'h00; req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_func3", 32'(mem_func3), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // aligned LW
        mem[4] <= 8'hEF; mem[5] <= 8'hBE; mem[6] <= 8'hAD; mem[7] <= 8'hDE;
        issue(1'b0, 3'b010, 8'h04, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1);
        exp_acc("lw_al", 1'b0, 3'b010, 8'h04, 8'h00);
        exp_rsp("lw_al");

        // misaligned SW, issued in the response cycle of the previous request
        issue(1'b1, 3'b010, 8'h05, 32'h11223344, {1'b0, 32'h0}, 1'b1);
        exp_acc("sw_split", 1'b1, 3'b000, 8'h05, 8'h44);
        exp_acc("sw_split", 1'b1, 3'b000, 8'h06, 8'h33);
        exp_acc("sw_split", 1'b1, 3'b000, 8'h07, 8'h22);
        exp_acc("sw_split", 1'b1, 3'b000, 8'h08, 8'h11);
        exp_rsp("sw_split");
        check("sw_mem05", 32'(mem[5]), 32'h44);
        check("sw_mem06", 32'(mem[6]), 32'h33);
        check("sw_mem07", 32'(mem[7]), 32'h22);
        check("sw_mem08", 32'(mem[8]), 32'h11);

        // misaligned LH / LHU
        mem[3] <= 8'h80; mem[4] <= 8'hFF;
        issue(1'b0, 3'b001, 8'h03, 32'h0, {1'b0, 32'hFFFFFF80}, 1'b1);
        exp_acc("lh_split", 1'b0, 3'b100, 8'h03, 8'h00);
        exp_acc("lh_split", 1'b0, 3'b100, 8'h04, 8'h00);
        exp_rsp("lh_split");
        issue(1'b0, 3'b101, 8'h03, 32'h0, {1'b0, 32'h0000FF80}, 1'b1);
        exp_acc("lhu_split", 1'b0, 3'b100, 8'h03, 8'h00);
        exp_acc("lhu_split", 1'b0, 3'b100, 8'h04, 8'h00);
        exp_rsp("lhu_split");

        // LW wrapping past the top of the address space
        mem[8'hFE] <= 8'h01; mem[8'hFF] <= 8'h02; mem[0] <= 8'h03; mem[1] <= 8'h04;
        issue(1'b0, 3'b010, 8'hFE, 32'h0, {1'b0, 32'h04030201}, 1'b1);
        exp_acc("lw_wrap", 1'b0, 3'b100, 8'hFE, 8'h00);
        exp_acc("lw_wrap", 1'b0, 3'b100, 8'hFF, 8'h00);
        exp_acc("lw_wrap", 1'b0, 3'b100, 8'h00, 8'h00);
        exp_acc("lw_wrap", 1'b0, 3'b100, 8'h01, 8'h00);
        exp_rsp("lw_wrap");

        // aligned LB sign extension and aligned SH
        mem[8'h10] <= 8'h9C;
        issue(1'b0, 3'b000, 8'h10, 32'h0, {1'b0, 32'hFFFFFF9C}, 1'b1);
        exp_acc("lb_al", 1'b0, 3'b000, 8'h10, 8'h00);
        exp_rsp("lb_al");
        issue(1'b1, 3'b001, 8'h30, 32'hCAFEBABE, {1'b0, 32'h0}, 1'b1);
        exp_acc("sh_al", 1'b1, 3'b001, 8'h30, 8'hBE);
        exp_rsp("sh_al");
        check("sh_mem30", 32'(mem[8'h30]), 32'hBE);
        check("sh_mem31", 32'(mem[8'h31]), 32'hBA);
        check("sh_mem32", 32'(mem[8'h32]), 32'h00);

        // illegal func3 on load and store
        issue(1'b0, 3'b011, 8'h10, 32'h0, {1'b1, 32'h0}, 1'b1);
        exp_fault_cycle("ill_ld");
        exp_rsp("ill_ld");
        issue(1'b1, 3'b100, 8'h40, 32'h55667788, {1'b1, 32'h0}, 1'b1);
        exp_fault_cycle("ill_st");
        exp_rsp("ill_st");
        check("ill_st_mem40", 32'(mem[8'h40]), 32'h00);

        // misaligned LW at 0x02: trapped or split depending on build
        mem[2] <= 8'h12; mem[3] <= 8'h34; mem[4] <= 8'h56; mem[5] <= 8'h78;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 8'h02, 32'h0, {1'b1, 32'h0}, 1'b1);
        exp_fault_cycle("lw_trap");
        exp_rsp("lw_trap");
`else
        issue(1'b0, 3'b010, 8'h02, 32'h0, {1'b0, 32'h78563412}, 1'b1);
        exp_acc("lw_mis", 1'b0, 3'b100, 8'h02, 8'h00);
        exp_acc("lw_mis", 1'b0, 3'b100, 8'h03, 8'h00);
        exp_acc("lw_mis", 1'b0, 3'b100, 8'h04, 8'h00);
        exp_acc("lw_mis", 1'b0, 3'b100, 8'h05, 8'h00);
        exp_rsp("lw_mis");
`endif

        // reset in the second SPLIT cycle of an SW: no response, first byte kept
        issue(1'b1, 3'b010, 8'h21, 32'hAABBCCDD, {1'b0, 32'h0}, 1'b0);
        exp_acc("sw_abort", 1'b1, 3'b000, 8'h21, 8'hDD);
        exp_acc("sw_abort", 1'b1, 3'b000, 8'h22, 8'hCC);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_mem_wr", 32'(mem_write), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_ready_after", 32'(req_ready), 32'd1);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        check("abort_mem21", 32'(mem[8'h21]), 32'hDD);
        check("abort_mem22", 32'(mem[8'h22]), 32'h00);

        // sequencer still works after the aborted sequence
        issue(1'b0, 3'b000, 8'h21, 32'h0, {1'b0, 32'hFFFFFFDD}, 1'b1);
        exp_acc("lb_post", 1'b0, 3'b000, 8'h21, 8'h00);
        exp_rsp("lb_post");

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
- Load/store sequencer between the execute stage and the data memory.
- Accepts one load or store per handshake and forwards aligned accesses to the memory as a single access.
- Splits misaligned halfword/word accesses into byte accesses, then reassembles and extends the load result.
- Returns a single-cycle response pulse to the pipeline, which uses req_ready as its stall source.

Parameters:
- ADDR_W, 8, byte address width; the address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_write  in  1  1 = store, 0 = load
- req_func3  in  3  RV32 load/store func3
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data (0 for stores)
- rsp_fault  out  1  request rejected; qualified by rsp_valid
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_func3  out  3  func3 presented to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational in the same cycle

Behaviour:
- Reset state: IDLE. req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_fault=0; all mem_* outputs 0. The internal byte counter and assembly register are cleared.
- Reset asserted mid-operation aborts the sequence. Bytes already written stay written, and no response is produced.
- Legal func3 values:
  - loads: LB=000, LH=001, LW=010, LBU=100, LHU=101
  - stores: SB=000, SH=001, SW=010
  - any other value is illegal.
- Alignment rules:
  - bytes are always aligned
  - halfword needs addr[0]=0
  - word needs addr[1:0]=00
- States:
  - IDLE: req_ready=1. When req_valid is high, latch the request and go to ACCESS (aligned), SPLIT (misaligned) or FAULT (illegal).
  - ACCESS: for one cycle drive mem_read or mem_write with the latched func3, addr and wdata. A load captures mem_rdata through the extender. Return to IDLE.
  - SPLIT: N = 2 (half) or 4 (word) cycles, byte counter k = 0..N-1.
    - mem_func3 is LBU for loads and SB for stores.
    - mem_addr = base+k, with carry dropped (0xFF+1 = 0x00).
    - mem_wdata[7:0] = wdata byte k.
    - For a load, mem_rdata[7:0] goes into assembly byte k.
    - After k = N-1, extend the result (bit 15 for LH, zero for LHU, none for LW) and go to IDLE.
  - FAULT: no memory access; go to IDLE.
- Response: rsp_valid is registered and pulses in the cycle after the last ACCESS/SPLIT/FAULT cycle. rsp_fault=1 only for FAULT. rsp_rdata holds its value until the next response.
- Latency from the accept edge T:
  - aligned: access at T+1, rsp_valid at T+2
  - split: accesses T+1..T+N, rsp_valid at T+N+1
  - fault: rsp_valid at T+2
- req_ready is 1 only in IDLE. A new request may be accepted in the same cycle rsp_valid is high.
- mem_read and mem_write are never high together, and both are 0 outside ACCESS/SPLIT.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: a misaligned halfword or word goes to FAULT instead of SPLIT. No memory access is made, and rsp_fault=1 at T+2.
- Undefined: misaligned accesses are split as described above. rsp_fault is asserted only for illegal func3.

Decomposition:
- Shared package/header holds:
  - the func3 load/store constants (same names the data memory uses)
  - the state encoding IDLE/ACCESS/SPLIT/FAULT
  - byte-count-per-func3 constants
- One sub-module is natural: lsu_load_ext, a combinational sign/zero extender driven by func3 and a 32-bit raw value. It is used by both the ACCESS and SPLIT paths.

Test Plan:
- Aligned LW, addr 0x04, memory returns 0xDEADBEEF -> one read with mem_func3=010 at T+1; rsp_valid at T+2 with rsp_rdata=0xDEADBEEF, rsp_fault=0.
- Misaligned SW, addr 0x05, wdata 0x11223344 -> four SB writes at 0x05..0x08 carrying 44, 33, 22, 11; rsp_valid at T+5; req_ready=0 during T+1..T+4.
- Misaligned LH, addr 0x03, bytes 0x80 then 0xFF -> rsp_rdata=0xFFFFFF80. The same access as LHU -> 0x0000FF80.
- Wrap case, LW at addr 0xFE with bytes 01, 02, 03, 04 -> reads at 0xFE, 0xFF, 0x00, 0x01; rsp_rdata=0x04030201.
- Illegal load func3=011 -> no mem_read/mem_write; rsp_valid at T+2 with rsp_fault=1, rsp_rdata=0.
- Reset pulled low in the second SPLIT cycle of an SW -> outputs return to reset values immediately; no rsp_valid; after release, req_ready=1.
- With LSU_MISALIGN_TRAP_EN, LW at 0x02 -> no memory access; rsp_fault=1 at T+2.
